// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared constants and state encoding for the waveform RAM sequencer
package wave_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 14;
    localparam int DIV_W_DEF  = 16;
    localparam int TABLE_MAX  = 1 << ADDR_W_DEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

endpackage

// File: rtl/wave_rate_gen.sv
// rtl/wave_rate_gen.sv - playback prescaler producing a one-cycle advance strobe every rate_div+1 cycles
module wave_rate_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             run,
    input  logic [DIV_W-1:0] rate_div,
    output logic             tick
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;

    // The divider is captured on clear so a host change mid-playback cannot glitch the period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            div_q <= '0;
        end else if (clear) begin
            cnt   <= '0;
            div_q <= rate_div;
        end else if (run) begin
            cnt <= (cnt == div_q) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = run && (cnt == div_q);

endmodule

// File: rtl/wave_mem_ctrl.sv
// rtl/wave_mem_ctrl.sv - time-shares the single-port waveform RAM between host table load and cyclic playback
module wave_mem_ctrl
    import wave_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIV_W  = DIV_W_DEF
) (
    input  logic              clk_100MHz,
    input  logic              rst_n,
    input  logic [ADDR_W:0]   cfg_len,
    input  logic [DIV_W-1:0]  rate_div,
    input  logic              load_start,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              load_done,
    input  logic              play_en,
    output logic              busy,
    output logic [1:0]        state,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [DATA_W-1:0] mem_dina,
    input  logic [DATA_W-1:0] mem_douta
);

    state_t              cur_state;
    state_t              next_state;
    logic [ADDR_W-1:0]   idx;
    logic [ADDR_W-1:0]   last_q;
    logic [1:0]          tag;
    logic                tick;
    logic                start_load;
    logic                start_play;
    logic                load_fire;
    logic                load_last;
    logic                play_run;

    // Length 0 behaves as 1; anything at or above the table size ends on the top address.
    function automatic logic [ADDR_W-1:0] last_index(input logic [ADDR_W:0] len);
        if (len == '0)
            return '0;
        else if (len[ADDR_W])
            return '1;
        else
            return ADDR_W'(len - 1'b1);
    endfunction

    assign start_load = (cur_state == ST_IDLE) && load_start;
    assign start_play = (cur_state == ST_IDLE) && !load_start && play_en;
    assign load_fire  = (cur_state == ST_LOAD) && wr_valid;
    assign load_last  = load_fire && (idx == last_q);
    assign play_run   = (cur_state == ST_PLAY) && play_en;

    wave_rate_gen #(
        .DIV_W(DIV_W)
    ) u_rate_gen (
        .clk      (clk_100MHz),
        .rst_n    (rst_n),
        .clear    (start_play),
        .run      (cur_state == ST_PLAY),
        .rate_div (rate_div),
        .tick     (tick)
    );

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n)
            cur_state <= ST_IDLE;
        else
            cur_state <= next_state;
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            ST_IDLE: begin
                if (load_start)
                    next_state = ST_LOAD;
                else if (play_en)
                    next_state = ST_PLAY;
            end
            ST_LOAD: if (load_last) next_state = ST_IDLE;
            ST_PLAY: if (!play_en)  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (cur_state != ST_IDLE);
        wr_ready = (cur_state == ST_LOAD);
    end

    assign state = cur_state;

    // tag[0] travels with the issued address, tag[1] with the RAM's registered read data.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            last_q       <= '0;
            tag          <= '0;
            mem_wea      <= 1'b0;
            mem_addra    <= '0;
            mem_dina     <= '0;
            load_done    <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            mem_wea      <= 1'b0;
            load_done    <= 1'b0;
            sample_valid <= 1'b0;

            if (start_load || start_play)
                last_q <= last_index(cfg_len);
            if (start_load)
                idx <= '0;

            if (start_play) begin
                mem_addra <= '0;
                tag       <= 2'b01;
            end else if (play_run) begin
                tag <= {tag[0], tick};
                if (tick)
                    mem_addra <= (mem_addra == last_q) ? '0 : mem_addra + 1'b1;
                if (tag[1]) begin
                    sample       <= mem_douta;
                    sample_valid <= 1'b1;
                end
            end else begin
                tag <= '0;
            end

            if (load_fire) begin
                mem_wea   <= 1'b1;
                mem_addra <= idx;
                mem_dina  <= wr_data;
                idx       <= idx + 1'b1;
            end
            if (load_last)
                load_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wave_mem_ctrl.sv
// tb/tb_wave_mem_ctrl.sv - self-checking bench for wave_mem_ctrl with a registered RAM and table/timing reference model
module tb_wave_mem_ctrl;
    import wave_pkg::*;

    localparam int AW = 8;
    localparam int DW = 14;
    localparam int VW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW:0]   cfg_len;
    logic [VW-1:0] rate_div;
    logic          load_start;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          load_done;
    logic          play_en;
    logic          busy;
    logic [1:0]    state;
    logic [DW-1:0] sample;
    logic          sample_valid;
    logic          mem_wea;
    logic [AW-1:0] mem_addra;
    logic [DW-1:0] mem_dina;
    logic [DW-1:0] mem_douta;

    logic [DW-1:0] ram     [TABLE_MAX];
    logic [DW-1:0] ref_mem [TABLE_MAX];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wave_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DIV_W(VW)) dut (
        .clk_100MHz   (clk),
        .rst_n        (rst_n),
        .cfg_len      (cfg_len),
        .rate_div     (rate_div),
        .load_start   (load_start),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .load_done    (load_done),
        .play_en      (play_en),
        .busy         (busy),
        .state        (state),
        .sample       (sample),
        .sample_valid (sample_valid),
        .mem_wea      (mem_wea),
        .mem_addra    (mem_addra),
        .mem_dina     (mem_dina),
        .mem_douta    (mem_douta)
    );

    // Registered read-first block RAM
    always @(posedge clk) begin
        if (mem_wea) ram[mem_addra] <= mem_dina;
        mem_douta <= ram[mem_addra];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input int len, input bit gappy, input bit with_play);
        logic [DW-1:0] d [TABLE_MAX];
        int beats, prev_idx;
        bit prev_fire, done;
        for (int i = 0; i < len; i++) d[i] = DW'(30 + $urandom_range(0, 16000));
        @(negedge clk);
        chk("load_idle", 32'(state), 32'(ST_IDLE));
        cfg_len    = (AW+1)'(len);
        load_start = 1'b1;
        play_en    = with_play;
        @(negedge clk);
        load_start = 1'b0;
        chk("load_state", 32'(state), 32'(ST_LOAD));
        chk("load_busy", 32'(busy), 1);
        beats = 0; prev_idx = 0; prev_fire = 1'b0; done = 1'b0;
        for (int cyc = 0; cyc < 4 * len + 8 && !done; cyc++) begin
            if (cyc > 0) begin
                chk("load_wea", 32'(mem_wea), 32'(prev_fire));
                if (prev_fire) begin
                    chk("load_addr", 32'(mem_addra), prev_idx);
                    chk("load_data", 32'(mem_dina), 32'(d[prev_idx]));
                    ref_mem[prev_idx] = d[prev_idx];
                end
                done = prev_fire && (prev_idx == len - 1);
                chk("load_done", 32'(load_done), 32'(done));
                chk("load_rdy", 32'(wr_ready), 32'(!done));
            end
            if (!done) begin
                wr_valid  = (beats < len) && (!gappy || (cyc % 2 == 0));
                wr_data   = d[(beats < len) ? beats : 0];
                prev_fire = wr_valid;
                prev_idx  = beats;
                if (wr_valid) beats++;
                @(negedge clk);
            end
        end
        wr_valid = 1'b0;
        play_en  = 1'b0;
        if (!done) chk("load_timeout", 0, 1);
        else chk("load_end_state", 32'(state), 32'(ST_IDLE));
    endtask

    task automatic do_play(input int len_cfg, input int rdiv, input int ncyc, input int ls_at);
        int len, n;
        bit exp_v;
        logic [DW-1:0] last;
        len  = (len_cfg == 0) ? 1 : len_cfg;
        n    = 0;
        last = '0;
        @(negedge clk);
        chk("play_idle", 32'(state), 32'(ST_IDLE));
        cfg_len  = (AW+1)'(len_cfg);
        rate_div = VW'(rdiv);
        play_en  = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            load_start = (k == ls_at);
            exp_v = (k >= 3) && ((k - 3) % (rdiv + 1) == 0);
            chk("play_state", 32'(state), 32'(ST_PLAY));
            chk("play_busy", 32'(busy), 1);
            chk("play_wea", 32'(mem_wea), 0);
            chk("play_valid", 32'(sample_valid), 32'(exp_v));
            if (exp_v) begin
                chk("play_sample", 32'(sample), 32'(ref_mem[n % len]));
                last = ref_mem[n % len];
                n++;
            end
        end
        play_en    = 1'b0;
        load_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stop_state", 32'(state), 32'(ST_IDLE));
            chk("stop_valid", 32'(sample_valid), 0);
            chk("stop_busy", 32'(busy), 0);
            if (n > 0) chk("stop_hold", 32'(sample), 32'(last));
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_len = '0; rate_div = '0; load_start = 1'b0;
        wr_valid = 1'b0; wr_data = '0; play_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ctl", 32'({state, wr_ready, load_done, busy, sample_valid, mem_wea}), 0);
        chk("rst_data", 32'({mem_addra, mem_dina}), 0);
        chk("rst_sample", 32'(sample), 0);
        rst_n = 1'b1;

        // Reset in the middle of a 24-beat load
        @(negedge clk);
        cfg_len = 9'd24; load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = DW'($urandom_range(0, 16383));
            @(negedge clk);
        end
        wr_valid = 1'b0;
        chk("midload_wea", 32'(mem_wea), 1);
        chk("midload_state", 32'(state), 32'(ST_LOAD));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ctl", 32'({state, wr_ready, load_done, busy, sample_valid, mem_wea}), 0);
        chk("midrst_data", 32'({mem_addra, mem_dina}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_load(24, 1'b0, 1'b0);
        do_play(24, 0, 60, 10);
        do_load(4, 1'b1, 1'b1);
        do_load(256, 1'b0, 1'b0);
        do_play(256, 3, 1100, 0);
        do_play(0, 1, 12, 0);
        do_play($urandom_range(1, 256), $urandom_range(0, 5), 80, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wave_mem_ctrl.md
# wave_mem_ctrl

Sequencer for the single-port 256×14 waveform block RAM of the function generator. Owns the RAM port and time-shares it between two users: a host loader that writes a sample table of programmable length, and a playback engine that streams the table cyclically to the DAC path at a programmable rate. Sits between the Ethernet command decoder (load/config side) and the DAC output register (sample side).

## Interface
- ADDR_W, 8, RAM address width; table holds up to 2^ADDR_W samples
- DATA_W, 14, sample width
- DIV_W, 16, width of rate divider
- clk_100MHz  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cfg_len  in  ADDR_W+1  table length in samples, 1..256; 0 treated as 1; latched at load_start and at play start
- rate_div  in  DIV_W  playback advances one address every rate_div+1 cycles; latched at play start
- load_start  in  1  one-cycle pulse, begin table load (accepted only in IDLE)
- wr_valid  in  1  host sample valid
- wr_data  in  DATA_W  host sample
- wr_ready  out  1  high throughout LOAD
- load_done  out  1  one-cycle pulse after last sample written
- play_en  in  1  level; high requests/continues playback
- busy  out  1  state != IDLE
- state  out  2  IDLE=0, LOAD=1, PLAY=2
- sample  out  DATA_W  registered output sample
- sample_valid  out  1  one-cycle pulse per new sample
- mem_wea  out  1  RAM write enable
- mem_addra  out  ADDR_W  RAM address
- mem_dina  out  DATA_W  RAM write data
- mem_douta  in  DATA_W  RAM read data, valid 1 cycle after address (registered RAM)

## Operation
- Reset: state IDLE; wr_ready, load_done, busy, sample_valid, mem_wea = 0; mem_addra, mem_dina, sample = 0; counters 0.
- IDLE: load_start has priority over play_en in the same cycle → LOAD. Else play_en=1 → PLAY. Else stay.
- LOAD: wr_ready=1. Each cycle with wr_valid=1: register mem_wea=1, mem_addra=idx, mem_dina=wr_data; idx++. After beat idx=len-1 accepted: next cycle mem_wea=1 for that final write, wr_ready=0, load_done=1, → IDLE. Cycles with wr_valid=0 drive mem_wea=0. play_en ignored during LOAD. load_start in LOAD/PLAY ignored.
- PLAY: mem_wea=0 always. Address counter starts at 0; prescaler counts 0..rate_div; on terminal count addr advances, wrapping len-1 → 0. A read is issued on entry and at each advance; read tag pipeline (2 stages) marks returned data; sample <= mem_douta and sample_valid=1 two cycles after address issue.
- play_en=0 in PLAY → IDLE next cycle; in-flight tags flushed, no further sample_valid; sample holds last value.
- Width rules: idx/addr are ADDR_W bits compared against len-1 (len held ADDR_W+1 bits, so len=256 wraps at 255).
- Reset asserted mid-LOAD or mid-PLAY: immediate return to reset values; partially loaded table contents undefined.

## Timing
- Load throughput 1 sample/cycle; RAM write lands 1 cycle after handshake (registered port).
- load_done: 1 cycle after the final handshake, coincident with final mem_wea.
- Playback latency: play_en rising in IDLE (cycle 0) → PLAY at cycle 1, addr 0 issued cycle 1, first sample_valid cycle 3.
- Sample period = rate_div+1 cycles; rate_div=0 gives one sample per cycle, continuous sample_valid.
- No combinational path from inputs to outputs.

## Structure
- Shared package wave_pkg: state encoding constants (ST_IDLE/ST_LOAD/ST_PLAY), ADDR_W, DATA_W defaults, table max length.
- One sub-module natural: wave_rate_gen (prescaler producing one-cycle advance strobe from rate_div, with synchronous clear on play start). FSM, load counter, read-tag pipeline in top.

## Test plan
- Reset mid-load: assert rst_n=0 after 5 of 24 beats → all outputs 0, state=0, wr_ready=0 within same cycle.
- Load 24 samples (cfg_len=24, sine table offset 30) back-to-back → 24 mem_wea pulses on addrs 0..23 with matching data, load_done on cycle after 24th handshake, state returns 0.
- Load with wr_valid toggling every other cycle, cfg_len=4 → exactly 4 writes, no write on idle cycles, load_done once.
- Play cfg_len=24, rate_div=0 → sample_valid continuous from cycle 3, sample sequence matches addrs 0..23,0,1… (wrap verified).
- Play cfg_len=256, rate_div=3 → sample_valid every 4 cycles, addr 255 → 0 wrap; drop play_en → no sample_valid after next cycle, state=0.
- Simultaneous load_start and play_en in IDLE → LOAD entered; load_start during PLAY ignored, busy stays 1, state=2.
